weight_fetch_ctrl: RTL and testbench

Producer-side controller for the weight/bias stream. On a `start` command it issues burst read requests to the memory read port for a contiguous block of 512-bit weight/bias beats. It forwards returned beats to the weight buffer's write side (`weight_and_bias_data` / `weight_and_bias_valid`). It throttles requests on the buffer's `weight_buffer_ready` and on an outstanding-beat credit limit. It sits between the layer scheduler and the weight buffer.

---
 rtl/weight_fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight/bias stream fetch controller: burst reads from memory, forwards beats to the weight buffer.
// Optional stall statistics counter built only when WEIGHT_FETCH_STAT_EN is defined.
module weight_fetch_ctrl #(
  parameter int unsigned MEM_DATA_WIDTH  = 512,
  parameter int unsigned MEM_ADDR_WIDTH  = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned BEAT_CNT_WIDTH  = 20
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] weight_base_addr,
  input  logic [BEAT_CNT_WIDTH-1:0] weight_beat_num,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0] rd_req_addr,
  output logic [7:0]                rd_req_len,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic [MEM_DATA_WIDTH-1:0] weight_and_bias_data,
  output logic                      weight_and_bias_valid,
  input  logic                      weight_buffer_ready,
  output logic                      err_unexpected,
  output logic [31:0]               stall_cycle_cnt
);

  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SUM_W      = ((OUT_W > 8) ? OUT_W : 8) + 1;
  localparam int unsigned BEAT_BYTES = MEM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic [OUT_W-1:0]          outstanding;
  logic [BEAT_CNT_WIDTH-1:0] req_remaining;
  logic [BEAT_CNT_WIDTH-1:0] rx_remaining;

  logic                      start_ok_c;
  logic [BEAT_CNT_WIDTH-1:0] cur_rem_c;
  logic [7:0]                len_c;
  logic                      credit_ok_c;
  logic                      want_req_c;
  logic                      issue_idle_c;
  logic                      issue_req_c;
  logic                      hs_c;
  logic                      beat_ok_c;
  logic                      beat_err_c;
  logic                      last_rx_c;

  // Request sizing and issue qualification; from IDLE the command inputs are used directly
  always_comb begin
    start_ok_c   = start && (state == IDLE);
    cur_rem_c    = (state == IDLE) ? weight_beat_num : req_remaining;
    len_c        = (cur_rem_c >= BEAT_CNT_WIDTH'(BURST_LEN)) ? 8'(BURST_LEN) : cur_rem_c[7:0];
    credit_ok_c  = (SUM_W'(outstanding) + SUM_W'(len_c)) <= SUM_W'(MAX_OUTSTANDING);
    want_req_c   = (state == REQ) && !rd_req_valid && (req_remaining != '0);
    issue_idle_c = start_ok_c && (weight_beat_num != '0) && weight_buffer_ready && credit_ok_c;
    issue_req_c  = want_req_c && weight_buffer_ready && credit_ok_c;
    hs_c         = rd_req_valid && rd_req_ready;
    beat_ok_c    = mem_rd_valid && (outstanding != '0);
    beat_err_c   = mem_rd_valid && (outstanding == '0);
    // Looking one beat ahead lets done follow the last forwarded beat by a single cycle
    last_rx_c    = (rx_remaining == '0) ||
                   ((rx_remaining == BEAT_CNT_WIDTH'(1)) && beat_ok_c);
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      rd_req_valid          <= 1'b0;
      rd_req_addr           <= '0;
      rd_req_len            <= '0;
      weight_and_bias_data  <= '0;
      weight_and_bias_valid <= 1'b0;
      err_unexpected        <= 1'b0;
      outstanding           <= '0;
      req_remaining         <= '0;
      rx_remaining          <= '0;
    end else begin
      done                  <= 1'b0;
      weight_and_bias_valid <= beat_ok_c;
      if (beat_ok_c) begin
        weight_and_bias_data <= mem_rd_data;
      end

      if (start_ok_c) begin
        err_unexpected <= beat_err_c;
      end else if (beat_err_c) begin
        err_unexpected <= 1'b1;
      end

      outstanding <= outstanding + (hs_c ? OUT_W'(rd_req_len) : OUT_W'(0)) - OUT_W'(beat_ok_c);

      if (beat_ok_c && (rx_remaining != '0)) begin
        rx_remaining <= rx_remaining - BEAT_CNT_WIDTH'(1);
      end

      // rd_req_addr advances past the accepted burst and becomes the next request address
      if (hs_c) begin
        rd_req_valid  <= 1'b0;
        rd_req_addr   <= rd_req_addr +
                         MEM_ADDR_WIDTH'(MEM_ADDR_WIDTH'(rd_req_len) * MEM_ADDR_WIDTH'(BEAT_BYTES));
        req_remaining <= req_remaining - BEAT_CNT_WIDTH'(rd_req_len);
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            rd_req_addr   <= weight_base_addr;
            req_remaining <= weight_beat_num;
            rx_remaining  <= weight_beat_num;
            state         <= (weight_beat_num == '0) ? DONE : REQ;
            if (issue_idle_c) begin
              rd_req_valid <= 1'b1;
              rd_req_len   <= len_c;
            end
          end
        end
        REQ: begin
          if (hs_c && (req_remaining == BEAT_CNT_WIDTH'(rd_req_len))) begin
            state <= DRAIN;
          end
          if (issue_req_c) begin
            rd_req_valid <= 1'b1;
            rd_req_len   <= len_c;
          end
        end
        DRAIN: begin
          if (last_rx_c) begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_FETCH_STAT_EN
  logic blocked_c;

  // A pending request waiting on rd_req_ready is not a stall
  assign blocked_c = want_req_c && !(weight_buffer_ready && credit_ok_c);

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycle_cnt <= '0;
    end else if (start_ok_c) begin
      stall_cycle_cnt <= '0;
    end else if (blocked_c && (stall_cycle_cnt != '1)) begin
      stall_cycle_cnt <= stall_cycle_cnt + 32'd1;
    end
  end
`else
  assign stall_cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: memory responder with beat scoreboard plus directed command scenarios.
module tb_weight_fetch_ctrl;

  logic         system_clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  weight_base_addr;
  logic [19:0]  weight_beat_num;
  logic         busy;
  logic         done;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [31:0]  rd_req_addr;
  logic [7:0]   rd_req_len;
  logic [511:0] mem_rd_data = '0;
  logic         mem_rd_valid = 1'b0;
  logic [511:0] weight_and_bias_data;
  logic         weight_and_bias_valid;
  logic         weight_buffer_ready;
  logic         err_unexpected;
  logic [31:0]  stall_cycle_cnt;

  weight_fetch_ctrl dut (
    .system_clk            (system_clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .weight_base_addr      (weight_base_addr),
    .weight_beat_num       (weight_beat_num),
    .busy                  (busy),
    .done                  (done),
    .rd_req_valid          (rd_req_valid),
    .rd_req_ready          (rd_req_ready),
    .rd_req_addr           (rd_req_addr),
    .rd_req_len            (rd_req_len),
    .mem_rd_data           (mem_rd_data),
    .mem_rd_valid          (mem_rd_valid),
    .weight_and_bias_data  (weight_and_bias_data),
    .weight_and_bias_valid (weight_and_bias_valid),
    .weight_buffer_ready   (weight_buffer_ready),
    .err_unexpected        (err_unexpected),
    .stall_cycle_cnt       (stall_cycle_cnt)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_C3C3}};
  endfunction

  // Memory responder / scoreboard state
  logic [511:0] mem_q[$];
  logic [511:0] exp_q[$];
  logic [31:0]  log_addr[$];
  logic [7:0]   log_len[$];
  int           beats_seen = 0;
  int           ret_count  = 0;
  int           ret_limit  = -1;
  int           ret_pct    = 100;
  int           inject_req = 0;
  int           inject_done = 0;
  logic         prev_pend = 1'b0;
  logic [31:0]  prev_addr;
  logic [7:0]   prev_len;
  logic [31:0]  rsp_a;
  logic [511:0] rsp_d;

  // Memory model: accepts requests, returns beats in order, checks forwarded beats
  always @(negedge system_clk) begin
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      mem_rd_valid = 1'b0;
      prev_pend    = 1'b0;
    end else begin
      if (weight_and_bias_valid) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", weight_and_bias_valid, 1'b0);
        end else begin
          rsp_d = exp_q.pop_front();
          check("beat_data", weight_and_bias_data, rsp_d);
        end
      end
      if (prev_pend) begin
        check("req_stable", {rd_req_valid, rd_req_addr, rd_req_len}, {1'b1, prev_addr, prev_len});
      end
      mem_rd_valid = 1'b0;
      if (inject_req != inject_done) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = {16{32'hDEAD_BEEF}};
        inject_done  = inject_req;
      end else if (mem_q.size() > 0 && (ret_limit < 0 || ret_count < ret_limit) &&
                   $urandom_range(0, 99) < ret_pct) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_q.pop_front();
        ret_count++;
      end
      if (rd_req_valid && rd_req_ready) begin
        log_addr.push_back(rd_req_addr);
        log_len.push_back(rd_req_len);
        for (int i = 0; i < int'(rd_req_len); i++) begin
          rsp_a = rd_req_addr + 32'(i * 64);
          mem_q.push_back(pat(rsp_a));
          exp_q.push_back(pat(rsp_a));
        end
        prev_pend = 1'b0;
      end else begin
        prev_pend = rd_req_valid;
        prev_addr = rd_req_addr;
        prev_len  = rd_req_len;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge system_clk);
      #2;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [19:0] num);
    weight_base_addr = base;
    weight_beat_num  = num;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic issue_start(input logic [31:0] base, input logic [19:0] num);
    pulse_start(base, num);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit   seen  = 1'b0;
    int   extra = 0;
    logic prev_wb;
    for (int i = 0; i < budget && !seen; i++) begin
      if (rnd) begin
        rd_req_ready        = 1'($urandom_range(0, 1));
        weight_buffer_ready = ($urandom_range(0, 3) != 0);
      end
      prev_wb = weight_and_bias_valid;
      tick(1);
      if (done) begin
        seen = 1'b1;
        check("done_after_last_beat", prev_wb, 1'b1);
        check("busy_at_done", busy, 1'b0);
      end
    end
    check("done_seen", seen, 1'b1);
    rd_req_ready        = 1'b1;
    weight_buffer_ready = 1'b1;
    repeat (4) begin
      tick(1);
      if (done) extra++;
    end
    check("single_done", extra, 0);
    check("busy_after_done", busy, 1'b0);
  endtask

  // Reference request sequence for a command, compared against the logged requests
  task automatic check_reqs(input int first, input logic [31:0] base, input int n);
    logic [31:0] a = base;
    int rem = n;
    int idx = first;
    int len;
    check("req_count", log_addr.size() - first, (n + 15) / 16);
    while (rem > 0 && idx < log_addr.size()) begin
      len = (rem > 16) ? 16 : rem;
      check("req_addr", log_addr[idx], a);
      check("req_len", log_len[idx], len);
      a   = a + 32'(len * 64);
      rem = rem - len;
      idx++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_req_valid"}, rd_req_valid, 1'b0);
    check({tag, "_wb_valid"}, weight_and_bias_valid, 1'b0);
    check({tag, "_err"}, err_unexpected, 1'b0);
    check({tag, "_rd_req_addr"}, rd_req_addr, 32'd0);
    check({tag, "_rd_req_len"}, rd_req_len, 8'd0);
    check({tag, "_wb_data"}, weight_and_bias_data, 512'd0);
    check({tag, "_stall"}, stall_cycle_cnt, 32'd0);
  endtask

  int lb;
  int b0;
  int exp_stall;
  bit hit;

  initial begin
    rst_n = 1'b0; start = 1'b0; weight_base_addr = '0; weight_beat_num = '0;
    rd_req_ready = 1'b0; weight_buffer_ready = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Basic fetch
    rd_req_ready = 1'b1;
    lb = log_addr.size(); b0 = beats_seen;
    issue_start(32'h1000, 40);
    wait_done(1000, 1'b0);
    check("basic_beats", beats_seen - b0, 40);
    check("basic_scoreboard_empty", exp_q.size(), 0);
    check_reqs(lb, 32'h1000, 40);

    // Backpressure with a pending request
    rd_req_ready = 1'b0;
    lb = log_addr.size(); b0 = beats_seen;
    issue_start(32'h2000, 24);
    check("bp_req_raised", {rd_req_valid, rd_req_addr, rd_req_len}, {1'b1, 32'h2000, 8'd16});
    weight_buffer_ready = 1'b0;
    repeat (5) begin
      tick(1);
      check("bp_req_held", {rd_req_valid, rd_req_addr, rd_req_len}, {1'b1, 32'h2000, 8'd16});
    end
    rd_req_ready = 1'b1;
    tick(1);
    repeat (6) begin
      check("bp_no_new_req", rd_req_valid, 1'b0);
      tick(1);
    end
    check("bp_no_new_req", rd_req_valid, 1'b0);
    weight_buffer_ready = 1'b1;
    wait_done(1000, 1'b0);
`ifdef WEIGHT_FETCH_STAT_EN
    exp_stall = 6;
`else
    exp_stall = 0;
`endif
    check("bp_stall_cnt", stall_cycle_cnt, 32'(exp_stall));
    check("bp_beats", beats_seen - b0, 24);
    check_reqs(lb, 32'h2000, 24);

    // Credit limit: no returns for 100 cycles
    lb = log_addr.size(); b0 = beats_seen;
    ret_limit = ret_count;
    issue_start(32'h0001_0000, 200);
    tick(100);
    check("credit_reqs_blocked", log_addr.size() - lb, 4);
    check("credit_no_pending", rd_req_valid, 1'b0);
    ret_limit = ret_count + 15;
    tick(40);
    check("credit_reqs_after_15", log_addr.size() - lb, 4);
    ret_limit = ret_limit + 1;
    tick(10);
    check("credit_reqs_after_16", log_addr.size() - lb, 5);
    ret_limit = -1;
    wait_done(3000, 1'b0);
    check("credit_beats", beats_seen - b0, 200);
    check("credit_err", err_unexpected, 1'b0);
    check_reqs(lb, 32'h0001_0000, 200);

    // Random handshakes, random returns, address wrap
    ret_pct = 60;
    lb = log_addr.size(); b0 = beats_seen;
    issue_start(32'hFFFF_F000, 100);
    wait_done(5000, 1'b1);
    ret_pct = 100;
    check("rand_beats", beats_seen - b0, 100);
    check("rand_scoreboard_empty", exp_q.size(), 0);
    check_reqs(lb, 32'hFFFF_F000, 100);

    // Start while busy is ignored
    lb = log_addr.size(); b0 = beats_seen;
    issue_start(32'h5000, 32);
    tick(3);
    pulse_start(32'h9000, 4);
    wait_done(1000, 1'b0);
    check("busy_start_beats", beats_seen - b0, 32);
    check_reqs(lb, 32'h5000, 32);

    // Zero-length command
    lb = log_addr.size();
    pulse_start(32'h7000, 0);
    check("zero_busy_n1", {busy, done}, 2'b10);
    tick(1);
    check("zero_done_n2", {busy, done}, 2'b01);
    tick(1);
    check("zero_done_pulse", done, 1'b0);
    check("zero_no_reqs", log_addr.size() - lb, 0);

    // Unsolicited beat in IDLE
    b0 = beats_seen;
    inject_req++;
    tick(4);
    check("unsol_err", err_unexpected, 1'b1);
    check("unsol_not_fwd", beats_seen - b0, 0);
    lb = log_addr.size();
    issue_start(32'h6000, 8);
    check("err_cleared", err_unexpected, 1'b0);
    wait_done(500, 1'b0);
    check_reqs(lb, 32'h6000, 8);

    // Reset mid-burst, then a fresh command
    b0 = beats_seen;
    issue_start(32'h3000, 40);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick(1);
      if (beats_seen - b0 >= 20) hit = 1'b1;
    end
    check("rst_reached_20", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    lb = log_addr.size(); b0 = beats_seen;
    issue_start(32'h4000, 8);
    wait_done(500, 1'b0);
    check("post_rst_beats", beats_seen - b0, 8);
    check("post_rst_err", err_unexpected, 1'b0);
    check_reqs(lb, 32'h4000, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
